// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - self-test result monitor with first-fail capture, watchdog and verdict LEDs
module test_monitor #(
    parameter int               NUM_CH  = 2,
    parameter int               CH_W    = 4,
    parameter int               STEP_W  = 8,
    parameter int               TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_CYC = 24'd10000000,
    parameter int               BLINK_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] test_step,
    input  logic [NUM_CH-1:0] test_good,
    input  logic [NUM_CH-1:0] test_ended,
    output logic [STEP_W-1:0] pass_cnt,
    output logic [STEP_W-1:0] fail_cnt,
    output logic              first_fail_vld,
    output logic [CH_W-1:0]   first_fail_ch,
    output logic [STEP_W-1:0] first_fail_step,
    output logic [1:0]        verdict,
    output logic              led_g,
    output logic              led_r
);

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_PASSED  = 2'd1,
        ST_FAILED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } verdict_t;

    localparam int               PC_W     = $clog2(NUM_CH + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    verdict_t            verdict_q;
    logic [NUM_CH-1:0]   ended_q;
    logic [STEP_W-1:0]   step_idx [NUM_CH];
    logic [TMO_W-1:0]    wdog_q;
    logic [BLINK_W-1:0]  blink_div_q;
    logic                blink_q;

    logic [NUM_CH-1:0]   acc;
    logic [NUM_CH-1:0]   good_acc;
    logic [NUM_CH-1:0]   bad_acc;
    logic [NUM_CH-1:0]   ended_nxt;
    logic                all_ended;
    logic                any_acc;
    logic                fail_any;
    logic                expire;
    logic [PC_W-1:0]     good_pc;
    logic [PC_W-1:0]     bad_pc;
    logic [CH_W-1:0]     fail_ch;
    logic [STEP_W-1:0]   fail_step;

    // A step counts only if its channel had not ended before this cycle
    assign acc       = test_step & ~ended_q;
    assign good_acc  = acc & test_good;
    assign bad_acc   = acc & ~test_good;
    assign ended_nxt = ended_q | test_ended;
    assign all_ended = &ended_nxt;
    assign any_acc   = |acc;
    assign fail_any  = |bad_acc;
    assign expire    = (wdog_q == TMO_LAST) && !any_acc;
    assign verdict   = verdict_q;

    function automatic logic [STEP_W-1:0] sat_add(input logic [STEP_W-1:0] a,
                                                   input logic [PC_W-1:0]   b);
        logic [STEP_W+PC_W:0] s;
        s = {{(PC_W+1){1'b0}}, a} + {{(STEP_W+1){1'b0}}, b};
        if (s > {{(PC_W+1){1'b0}}, {STEP_W{1'b1}}})
            return '1;
        return s[STEP_W-1:0];
    endfunction

    // Popcounts of accepted results and the lowest-numbered failing channel
    always_comb begin
        good_pc   = '0;
        bad_pc    = '0;
        fail_ch   = '0;
        fail_step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (good_acc[i]) good_pc = good_pc + 1'b1;
            if (bad_acc[i])  bad_pc  = bad_pc + 1'b1;
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bad_acc[i]) begin
                fail_ch   = CH_W'(i);
                fail_step = step_idx[i];
            end
        end
    end

    // Sticky ended flags and per-channel saturating good-step index
    always_ff @(posedge clk) begin
        if (rst) begin
            ended_q <= '0;
            for (int i = 0; i < NUM_CH; i++) step_idx[i] <= '0;
        end else begin
            ended_q <= ended_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (good_acc[i] && (step_idx[i] != {STEP_W{1'b1}}))
                    step_idx[i] <= step_idx[i] + 1'b1;
            end
        end
    end

    // Global totals, frozen once a verdict has been reached
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (verdict_q == ST_RUNNING) begin
            pass_cnt <= sat_add(pass_cnt, good_pc);
            fail_cnt <= sat_add(fail_cnt, bad_pc);
        end
    end

    // Capture the first failing channel and its step index before this cycle's update
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_vld  <= 1'b0;
            first_fail_ch   <= '0;
            first_fail_step <= '0;
        end else if (!first_fail_vld && fail_any) begin
            first_fail_vld  <= 1'b1;
            first_fail_ch   <= fail_ch;
            first_fail_step <= fail_step;
        end
    end

    // Watchdog: restarted by any accepted step, otherwise counts while running
    always_ff @(posedge clk) begin
        if (rst)
            wdog_q <= '0;
        else if (any_acc)
            wdog_q <= '0;
        else if (verdict_q == ST_RUNNING)
            wdog_q <= wdog_q + 1'b1;
    end

    // Verdict FSM; completion takes priority over watchdog expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            verdict_q <= ST_RUNNING;
        end else begin
            case (verdict_q)
                ST_RUNNING: begin
                    if (all_ended)
                        verdict_q <= (first_fail_vld || fail_any) ? ST_FAILED : ST_PASSED;
                    else if (expire)
                        verdict_q <= ST_TIMEOUT;
                end
                default: verdict_q <= verdict_q;
            endcase
        end
    end

    // Free-running blink divider; blink bit toggles on every wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_div_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_div_q <= blink_div_q + 1'b1;
            if (&blink_div_q)
                blink_q <= ~blink_q;
        end
    end

    // Indicator LEDs registered from the current verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            led_g <= 1'b0;
            led_r <= 1'b0;
        end else begin
            case (verdict_q)
                ST_RUNNING: begin led_g <= blink_q; led_r <= first_fail_vld; end
                ST_PASSED:  begin led_g <= 1'b1;    led_r <= 1'b0;           end
                ST_FAILED:  begin led_g <= 1'b0;    led_r <= 1'b1;           end
                default:    begin led_g <= 1'b0;    led_r <= blink_q;        end
            endcase
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - table, directed and model-checked random bench for test_monitor
module tb_test_monitor;

    localparam int STEP_W = 3;
    localparam int SMAX   = 7;
    localparam int TMO    = 16;
    localparam int BLINKP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] test_step = '0;
    logic [1:0] test_good = '0;
    logic [1:0] test_ended = '0;
    logic [STEP_W-1:0] pass_cnt, fail_cnt, first_fail_step;
    logic       first_fail_vld;
    logic [3:0] first_fail_ch;
    logic [1:0] verdict;
    logic       led_g, led_r;

    int errors = 0;
    int checks = 0;

    test_monitor #(
        .NUM_CH(2), .CH_W(4), .STEP_W(STEP_W), .TMO_W(8),
        .TMO_CYC(8'd16), .BLINK_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .test_step(test_step), .test_good(test_good), .test_ended(test_ended),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
        .first_fail_step(first_fail_step), .verdict(verdict),
        .led_g(led_g), .led_r(led_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] st, input logic [1:0] gd,
                         input logic [1:0] en);
        rst = r; test_step = st; test_good = gd; test_ended = en;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst; logic [1:0] st; logic [1:0] gd; logic [1:0] en;
        int p; int f; int ffv; int ch; int fs; int vd;
        logic cg; logic eg; logic cr; logic er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [1:0] st, input logic [1:0] gd,
                                input logic [1:0] en, input int p, input int f, input int ffv,
                                input int ch, input int fs, input int vd,
                                input logic cg, input logic eg, input logic cr, input logic er);
        vec_t v;
        v.rst = r; v.st = st; v.gd = gd; v.en = en;
        v.p = p; v.f = f; v.ffv = ffv; v.ch = ch; v.fs = fs; v.vd = vd;
        v.cg = cg; v.eg = eg; v.cr = cr; v.er = er;
        return v;
    endfunction

    // behavioural reference: counts of events, cycles since reset, cycles since last step
    int m_end[2], m_idx[2];
    int m_pass, m_fail, m_ffv, m_ffch, m_ffs, m_verd, m_idle, m_n, m_ledg, m_ledr;

    function automatic int smin(input int a);
        return (a > SMAX) ? SMAX : a;
    endfunction

    task automatic model_step(input logic r, input logic [1:0] st, input logic [1:0] gd,
                              input logic [1:0] en);
        int np, nb, bch, blink, old_verd, old_ffv;
        bit a[2];
        if (r) begin
            m_end = '{0, 0}; m_idx = '{0, 0};
            m_pass = 0; m_fail = 0; m_ffv = 0; m_ffch = 0; m_ffs = 0;
            m_verd = 0; m_idle = 0; m_n = 0; m_ledg = 0; m_ledr = 0;
            return;
        end
        blink = (m_n / BLINKP) % 2;
        case (m_verd)
            0: begin m_ledg = blink; m_ledr = m_ffv; end
            1: begin m_ledg = 1;     m_ledr = 0;     end
            2: begin m_ledg = 0;     m_ledr = 1;     end
            default: begin m_ledg = 0; m_ledr = blink; end
        endcase
        np = 0; nb = 0; bch = -1;
        for (int i = 0; i < 2; i++) begin
            a[i] = st[i] && (m_end[i] == 0);
            if (a[i]) begin
                if (gd[i]) np++;
                else begin nb++; if (bch < 0) bch = i; end
            end
        end
        old_verd = m_verd; old_ffv = m_ffv;
        if (old_verd == 0) begin
            m_pass = smin(m_pass + np);
            m_fail = smin(m_fail + nb);
        end
        if (m_ffv == 0 && bch >= 0) begin
            m_ffv = 1; m_ffch = bch; m_ffs = m_idx[bch];
        end
        for (int i = 0; i < 2; i++) begin
            if (a[i] && gd[i]) m_idx[i] = smin(m_idx[i] + 1);
            if (en[i]) m_end[i] = 1;
        end
        if (old_verd == 0) begin
            if (m_end[0] == 1 && m_end[1] == 1)
                m_verd = (old_ffv == 1 || nb > 0) ? 2 : 1;
            else if (m_idle == TMO - 1 && np + nb == 0)
                m_verd = 3;
        end
        if (np + nb > 0) m_idle = 0;
        else if (old_verd == 0) m_idle++;
        m_n++;
    endtask

    task automatic rcycle(input logic r, input logic [1:0] st, input logic [1:0] gd,
                          input logic [1:0] en);
        model_step(r, st, gd, en);
        drive(r, st, gd, en);
        chk("rnd_pass", pass_cnt, m_pass);
        chk("rnd_fail", fail_cnt, m_fail);
        chk("rnd_ffv", first_fail_vld, m_ffv);
        chk("rnd_ffch", first_fail_ch, m_ffch);
        chk("rnd_ffstep", first_fail_step, m_ffs);
        chk("rnd_verdict", verdict, m_verd);
        chk("rnd_led_g", led_g, m_ledg);
        chk("rnd_led_r", led_r, m_ledr);
    endtask

    initial begin
        bit saw0, saw1;
        // clean pass run
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 3, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 3, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        // two failures in one cycle, ch0 wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 0, 0, 3, 2, 1, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 2, 1, 0, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 3, 3, 2, 1, 0, 2, 2, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 3, 2, 1, 0, 2, 2, 1, 0, 1, 1));
        // reset after a captured failure, then a clean run with step+ended together
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 3, 3, 3, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 1, 1, 1, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst, tbl[k].st, tbl[k].gd, tbl[k].en);
            chk($sformatf("tbl%0d_pass", k), pass_cnt, tbl[k].p);
            chk($sformatf("tbl%0d_fail", k), fail_cnt, tbl[k].f);
            chk($sformatf("tbl%0d_ffv", k), first_fail_vld, tbl[k].ffv);
            chk($sformatf("tbl%0d_ffch", k), first_fail_ch, tbl[k].ch);
            chk($sformatf("tbl%0d_ffstep", k), first_fail_step, tbl[k].fs);
            chk($sformatf("tbl%0d_verdict", k), verdict, tbl[k].vd);
            if (tbl[k].cg) chk($sformatf("tbl%0d_led_g", k), led_g, tbl[k].eg);
            if (tbl[k].cr) chk($sformatf("tbl%0d_led_r", k), led_r, tbl[k].er);
        end

        // ended channel keeps strobing failures: ignored, watchdog still expires
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        for (int k = 2; k <= TMO; k++) begin
            drive(0, 1, 0, 0);
            chk($sformatf("ended_verdict_%0d", k), verdict, (k == TMO) ? 3 : 0);
            chk("ended_fail", fail_cnt, 0);
            chk("ended_ffv", first_fail_vld, 0);
        end

        // saturation of pass count and step index
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(0, 1, 1, 0);
            chk($sformatf("sat_pass_%0d", k), pass_cnt, smin(k));
        end
        drive(0, 1, 0, 0);
        chk("sat_ffv", first_fail_vld, 1);
        chk("sat_ffch", first_fail_ch, 0);
        chk("sat_ffstep", first_fail_step, 7);
        chk("sat_fail", fail_cnt, 1);
        chk("sat_pass", pass_cnt, 7);

        // timeout exactly TMO cycles after the last step, red LED blinks
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        for (int k = 1; k <= TMO; k++) begin
            drive(0, 0, 0, 0);
            chk($sformatf("tmo_verdict_%0d", k), verdict, (k == TMO) ? 3 : 0);
        end
        saw0 = 0; saw1 = 0;
        drive(0, 0, 0, 0);
        for (int k = 0; k < 24; k++) begin
            drive(0, 0, 0, 0);
            chk("tmo_led_g", led_g, 0);
            if (led_r === 1'b1) saw1 = 1;
            if (led_r === 1'b0) saw0 = 1;
        end
        chk("tmo_led_r_high", saw1, 1);
        chk("tmo_led_r_low", saw0, 1);
        chk("tmo_verdict_hold", verdict, 3);

        // randomized run against the reference model
        rcycle(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic r;
            logic [1:0] st, gd, en;
            r  = ($urandom_range(0, 79) == 0);
            st = 2'($urandom);
            if ($urandom_range(0, 3) == 0) st = 2'b00;
            gd[0] = ($urandom_range(0, 9) != 0);
            gd[1] = ($urandom_range(0, 9) != 0);
            en[0] = ($urandom_range(0, 29) == 0);
            en[1] = ($urandom_range(0, 29) == 0);
            if (k % 200 > 150) begin st = 2'b00; en = 2'b00; end
            rcycle(r, st, gd, en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
